mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the single data memory port between instruction fetch (IF) and the load/store unit (LS) of the pipelined core. It accepts one request at a time, forwards it to memory, waits for the memory response and routes it back to the owning requester. LS has priority; a bounded starvation counter guarantees IF forward progress.

## Interface

- ADDR_WIDTH, 64, address width of all request ports
- DATA_WIDTH, 64, data width of all request/response ports
- MAX_WAIT, 4, consecutive LS wins while IF is waiting before IF is forced to win (1..15)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req_valid  in  1  IF read request
- if_req_ready  out  1  IF request accepted this cycle
- if_addr  in  ADDR_WIDTH  IF read address
- if_rsp_valid  out  1  IF response strobe, one cycle
- if_rsp_data  out  DATA_WIDTH  IF read data
- ls_req_valid  in  1  LS request
- ls_req_ready  out  1  LS request accepted this cycle
- ls_addr  in  ADDR_WIDTH  LS address
- ls_wen  in  1  1 = store, 0 = load
- ls_wdata  in  DATA_WIDTH  store data
- ls_wmask  in  DATA_WIDTH/8  store byte mask
- ls_rsp_valid  out  1  LS response strobe (load data or store ack)
- ls_rsp_data  out  DATA_WIDTH  LS load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  as LS  forwarded request fields (mem_wen=0, mem_wmask=0 for IF)
- mem_rsp_valid  in  1  memory response strobe
- mem_rsp_data  in  DATA_WIDTH  memory response data
- busy  out  1  a transaction is outstanding (state ≠ IDLE)

## Operation

- States: IDLE, WAIT_IF, WAIT_LS. One outstanding transaction maximum.
- Grant selection in IDLE, when not locked: LS if ls_req_valid and not (if_req_valid and starve_cnt == MAX_WAIT); else IF if if_req_valid; else none.
- Lock: if mem_req_valid=1 and mem_req_ready=0, register the chosen requester (lock_valid=1, lock_id); next cycles use lock_id regardless of new arrivals until accepted. Lock clears on acceptance.
- mem_req_valid = IDLE and selected requester valid. mem_* fields mux from the selected requester combinationally.
- Acceptance: selected requester's req_ready = IDLE & mem_req_valid & mem_req_ready; other ready = 0. On acceptance → WAIT_IF or WAIT_LS.
- WAIT_x: on mem_rsp_valid, x_rsp_valid=1 and x_rsp_data=mem_rsp_data for that cycle, → IDLE. Other rsp_valid stays 0.
- mem_rsp_valid in IDLE: ignored, no rsp strobe.
- starve_cnt (4 bits): on LS acceptance while if_req_valid=1, increment (saturate at MAX_WAIT); on IF acceptance, clear; otherwise hold.
- Requesters hold valid and all fields stable until ready; arbiter does not check this.
- if_rsp_data/ls_rsp_data drive mem_rsp_data continuously; meaningful only with strobe.

## Timing

- Reset (rst=0): state=IDLE, lock_valid=0, starve_cnt=0 immediately (async). While rst=0 all ready, rsp_valid, mem_req_valid and busy are forced 0.
- Reset mid-transaction: outstanding transaction dropped; a memory response arriving after release is ignored (state IDLE).
- Request path fully combinational: mem_req_valid in the same cycle as req_valid, ready in the same cycle as mem_req_ready.
- Minimum turnaround: accept at edge N, mem_rsp_valid earliest cycle N+1, rsp strobe in that cycle, next acceptance at edge N+2. Response same cycle as mem_rsp_valid (zero added latency).
- Back-to-back: after response the arbiter is IDLE the next cycle; no request accepted in the response cycle.
- Simultaneous new request and response: response delivered, new request waits in IDLE.

## Test plan

- Single IF read, mem_req_ready=1, 1-cycle memory: if_addr=0x80000000 → if_req_ready same cycle, if_rsp_valid next cycle with memory data, busy high for 1 cycle.
- Both valid continuously, IF waiting, MAX_WAIT=4: grants LS,LS,LS,LS,IF,LS… ; starve_cnt 0→4→0.
- Lock: ls and if valid, mem_req_ready=0 for 3 cycles, LS deasserts nothing, IF stays; at ready=1 LS accepted, mem_addr never switches to if_addr during stall.
- Store: ls_wen=1, ls_wmask=0x0F, ls_wdata=0xDEADBEEF → mem_wen=1, mem_wmask=0x0F forwarded; ls_rsp_valid pulses on ack; if_rsp_valid stays 0.
- Reset during WAIT_LS, mem_rsp_valid one cycle after release → no ls_rsp_valid, busy=0, next IF request accepted normally.
- Spurious mem_rsp_valid in IDLE → no rsp strobes, state unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter: load/store has priority over instruction
// fetch, with a starvation counter that forces an IF grant after MAX_WAIT LS wins.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_WAIT   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req_valid,
    output logic                    if_req_ready,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_rsp_valid,
    output logic [DATA_WIDTH-1:0]   if_rsp_data,
    input  logic                    ls_req_valid,
    output logic                    ls_req_ready,
    input  logic [ADDR_WIDTH-1:0]   ls_addr,
    input  logic                    ls_wen,
    input  logic [DATA_WIDTH-1:0]   ls_wdata,
    input  logic [DATA_WIDTH/8-1:0] ls_wmask,
    output logic                    ls_rsp_valid,
    output logic [DATA_WIDTH-1:0]   ls_rsp_data,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_wen,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_LS = 2'd2
    } state_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_t     state_q, state_d;
    logic       lock_valid_q, lock_valid_d;
    logic       lock_ls_q, lock_ls_d;
    logic [3:0] starve_q, starve_d;

    logic sel_ls;
    logic sel_valid;
    logic idle;
    logic accept;

    // A stalled request keeps its owner until memory takes it, so a late LS
    // arrival cannot swap the address under a pending IF request.
    always_comb begin
        sel_ls = 1'b0;
        if (lock_valid_q) begin
            sel_ls = lock_ls_q;
        end else if (ls_req_valid && !(if_req_valid && starve_q == MAX_WAIT_C)) begin
            sel_ls = 1'b1;
        end
    end

    assign sel_valid     = sel_ls ? ls_req_valid : if_req_valid;
    assign idle          = rst && (state_q == IDLE);
    assign mem_req_valid = idle && sel_valid;
    assign accept        = mem_req_valid && mem_req_ready;
    assign if_req_ready  = accept && !sel_ls;
    assign ls_req_ready  = accept && sel_ls;

    assign mem_addr  = sel_ls ? ls_addr : if_addr;
    assign mem_wen   = sel_ls && ls_wen;
    assign mem_wdata = sel_ls ? ls_wdata : '0;
    assign mem_wmask = sel_ls ? ls_wmask : '0;

    assign if_rsp_valid = rst && (state_q == WAIT_IF) && mem_rsp_valid;
    assign ls_rsp_valid = rst && (state_q == WAIT_LS) && mem_rsp_valid;
    assign if_rsp_data  = mem_rsp_data;
    assign ls_rsp_data  = mem_rsp_data;
    assign busy         = rst && (state_q != IDLE);

    // NOTE: every combinational output gets a default before the case so no
    // path leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_d      = state_q;
        lock_valid_d = lock_valid_q;
        lock_ls_d    = lock_ls_q;
        starve_d     = starve_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = sel_ls ? WAIT_LS : WAIT_IF;
                    lock_valid_d = 1'b0;
                    if (!sel_ls) begin
                        starve_d = '0;
                    end else if (if_req_valid && starve_q < MAX_WAIT_C) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (mem_req_valid) begin
                    lock_valid_d = 1'b1;
                    lock_ls_d    = sel_ls;
                end
            end
            WAIT_IF, WAIT_LS: begin
                if (mem_rsp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            lock_valid_q <= 1'b0;
            lock_ls_q    <= 1'b0;
            starve_q     <= '0;
        end else begin
            state_q      <= state_d;
            lock_valid_q <= lock_valid_d;
            lock_ls_q    <= lock_ls_d;
            starve_q     <= starve_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected grants and responses
// into queues; a negedge monitor pops and compares whenever the DUT strobes.
module tb_mem_arbiter;

    typedef struct {
        bit          is_ls;
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } grant_t;

    typedef struct {
        bit          is_ls;
        logic [63:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [63:0] if_addr, if_rsp_data;
    logic        ls_req_valid, ls_req_ready, ls_wen, ls_rsp_valid;
    logic [63:0] ls_addr, ls_wdata, ls_rsp_data;
    logic [7:0]  ls_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rsp_data;
    logic [7:0]  mem_wmask;
    logic        busy;

    int checks = 0;
    int errors = 0;

    grant_t grant_q[$];
    rsp_t   rsp_q[$];

    mem_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic exp_grant(input bit is_ls, input logic [63:0] addr, input logic wen,
                             input logic [63:0] wdata, input logic [7:0] wmask);
        grant_t g;
        g.is_ls = is_ls; g.addr = addr; g.wen = wen; g.wdata = wdata; g.wmask = wmask;
        grant_q.push_back(g);
    endtask

    task automatic exp_rsp(input bit is_ls, input logic [63:0] data);
        rsp_t r;
        r.is_ls = is_ls; r.data = data;
        rsp_q.push_back(r);
    endtask

    // Monitor: every accepted request and every response strobe must match
    // the next queued expectation.
    initial begin
        grant_t g;
        rsp_t   r;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && mem_req_valid && mem_req_ready) begin
                if (grant_q.size() == 0) begin
                    check("unexpected_grant", mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    g = grant_q.pop_front();
                    check("grant_ls_ready", {63'd0, ls_req_ready}, {63'd0, g.is_ls});
                    check("grant_if_ready", {63'd0, if_req_ready}, {63'd0, !g.is_ls});
                    check("grant_addr", mem_addr, g.addr);
                    check("grant_wen", {63'd0, mem_wen}, {63'd0, g.wen});
                    check("grant_wmask", {56'd0, mem_wmask}, {56'd0, g.wmask});
                    if (g.is_ls) check("grant_wdata", mem_wdata, g.wdata);
                end
            end
            if (if_rsp_valid || ls_rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rsp", {62'd0, ls_rsp_valid, if_rsp_valid}, 64'd0);
                end else begin
                    r = rsp_q.pop_front();
                    check("rsp_ls_valid", {63'd0, ls_rsp_valid}, {63'd0, r.is_ls});
                    check("rsp_if_valid", {63'd0, if_rsp_valid}, {63'd0, !r.is_ls});
                    check("rsp_data", r.is_ls ? ls_rsp_data : if_rsp_data, r.data);
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        if_req_valid = 1'b0; if_addr = '0;
        ls_req_valid = 1'b0; ls_addr = '0; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;

        // Reset forces all handshake outputs low even with live inputs.
        #1;
        if_req_valid = 1'b1; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
        at_neg();
        check("rst_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
        check("rst_if_req_ready", {63'd0, if_req_ready}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_rsp", {62'd0, if_rsp_valid, ls_rsp_valid}, 64'd0);
        cyc();
        if_req_valid = 1'b0; mem_rsp_valid = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();

        // Single IF read with a one-cycle memory.
        if_req_valid = 1'b1; if_addr = 64'h8000_0000;
        exp_grant(1'b0, 64'h8000_0000, 1'b0, 64'd0, 8'h00);
        at_neg();
        check("if_ready_same_cycle", {63'd0, if_req_ready}, 64'd1);
        check("if_busy_before", {63'd0, busy}, 64'd0);
        cyc();
        if_req_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 64'h1111_2222_3333_4444;
        exp_rsp(1'b0, 64'h1111_2222_3333_4444);
        at_neg();
        check("if_busy_wait", {63'd0, busy}, 64'd1);
        cyc();
        mem_rsp_valid = 1'b0;
        at_neg();
        check("if_busy_after", {63'd0, busy}, 64'd0);
        cyc();

        // Both valid continuously: LS x4, then IF forced, then LS.
        if_req_valid = 1'b1; if_addr = 64'h8000_0040;
        ls_req_valid = 1'b1; ls_addr = 64'h0000_0100;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) exp_grant(1'b0, 64'h8000_0040, 1'b0, 64'd0, 8'h00);
            else        exp_grant(1'b1, 64'h0000_0100, 1'b0, 64'd0, 8'h00);
            at_neg();
            cyc();
            mem_rsp_valid = 1'b1; mem_rsp_data = 64'hA000 + 64'(k);
            exp_rsp(k != 4, 64'hA000 + 64'(k));
            if (k == 5) begin
                if_req_valid = 1'b0; ls_req_valid = 1'b0;
            end
            at_neg();
            cyc();
            mem_rsp_valid = 1'b0;
        end
        at_neg();
        cyc();

        // Stall with both valid: LS owns the port throughout.
        ls_req_valid = 1'b1; ls_addr = 64'h2000;
        if_req_valid = 1'b1; if_addr = 64'h3000;
        mem_req_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            at_neg();
            check("stall_ls_valid", {63'd0, mem_req_valid}, 64'd1);
            check("stall_ls_addr", mem_addr, 64'h2000);
            check("stall_readys", {62'd0, ls_req_ready, if_req_ready}, 64'd0);
            cyc();
        end
        mem_req_ready = 1'b1;
        exp_grant(1'b1, 64'h2000, 1'b0, 64'd0, 8'h00);
        at_neg();
        cyc();
        ls_req_valid = 1'b0; if_req_valid = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'hB0B0;
        exp_rsp(1'b1, 64'hB0B0);
        at_neg();
        cyc();
        mem_rsp_valid = 1'b0;

        // Stalled IF keeps the port when LS shows up mid-stall.
        if_req_valid = 1'b1; if_addr = 64'h4000; mem_req_ready = 1'b0;
        at_neg();
        check("lock_if_addr0", mem_addr, 64'h4000);
        cyc();
        ls_req_valid = 1'b1; ls_addr = 64'h5000;
        for (int k = 0; k < 2; k++) begin
            at_neg();
            check("lock_if_addr", mem_addr, 64'h4000);
            check("lock_ls_ready", {63'd0, ls_req_ready}, 64'd0);
            cyc();
        end
        mem_req_ready = 1'b1;
        exp_grant(1'b0, 64'h4000, 1'b0, 64'd0, 8'h00);
        at_neg();
        cyc();
        if_req_valid = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'hC0C0;
        exp_rsp(1'b0, 64'hC0C0);
        at_neg();
        cyc();
        mem_rsp_valid = 1'b0;
        exp_grant(1'b1, 64'h5000, 1'b0, 64'd0, 8'h00);
        at_neg();
        cyc();
        ls_req_valid = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'hD0D0;
        exp_rsp(1'b1, 64'hD0D0);
        at_neg();
        cyc();
        mem_rsp_valid = 1'b0;

        // Store forwarding.
        ls_req_valid = 1'b1; ls_addr = 64'h6000; ls_wen = 1'b1;
        ls_wdata = 64'hDEAD_BEEF; ls_wmask = 8'h0F;
        exp_grant(1'b1, 64'h6000, 1'b1, 64'hDEAD_BEEF, 8'h0F);
        at_neg();
        cyc();
        ls_req_valid = 1'b0; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'hACED;
        exp_rsp(1'b1, 64'hACED);
        at_neg();
        check("store_no_if_rsp", {63'd0, if_rsp_valid}, 64'd0);
        cyc();
        mem_rsp_valid = 1'b0;

        // Reset while waiting on LS; late response must be dropped.
        ls_req_valid = 1'b1; ls_addr = 64'h7000;
        exp_grant(1'b1, 64'h7000, 1'b0, 64'd0, 8'h00);
        at_neg();
        cyc();
        ls_req_valid = 1'b0;
        at_neg();
        check("wait_ls_busy", {63'd0, busy}, 64'd1);
        cyc();
        rst = 1'b0;
        at_neg();
        check("midrst_busy", {63'd0, busy}, 64'd0);
        cyc();
        rst = 1'b1;
        at_neg();
        check("post_rst_busy", {63'd0, busy}, 64'd0);
        cyc();
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'hBAD0;
        at_neg();
        check("late_rsp_dropped", {62'd0, ls_rsp_valid, if_rsp_valid}, 64'd0);
        check("late_rsp_busy", {63'd0, busy}, 64'd0);
        cyc();
        mem_rsp_valid = 1'b0;
        if_req_valid = 1'b1; if_addr = 64'h8000;
        exp_grant(1'b0, 64'h8000, 1'b0, 64'd0, 8'h00);
        at_neg();
        check("post_rst_if_ready", {63'd0, if_req_ready}, 64'd1);
        cyc();
        if_req_valid = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'hE0E0;
        exp_rsp(1'b0, 64'hE0E0);
        at_neg();
        cyc();
        mem_rsp_valid = 1'b0;

        // Spurious response while idle.
        at_neg();
        cyc();
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'hF00D;
        at_neg();
        check("spurious_no_rsp", {62'd0, ls_rsp_valid, if_rsp_valid}, 64'd0);
        check("spurious_busy", {63'd0, busy}, 64'd0);
        cyc();
        mem_rsp_valid = 1'b0;
        at_neg();
        check("spurious_after_busy", {63'd0, busy}, 64'd0);

        cyc();
        cyc();
        check("grant_q_drained", 64'(grant_q.size()), 64'd0);
        check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
